// File: rtl/vend_txn_controller.sv
// vend_txn_controller: vending-machine transaction controller.
// Arbitrates the $5/$10 coin channels round-robin, accumulates credit in $5
// units, runs the dispense handshake and then pays change one $5 coin at a
// time through the hopper handshake.
// Optional feature macro: VEND_TIMEOUT_EN enables the idle-credit timeout in
// COLLECT (TIMEOUT_CYCLES cycles without a grant refunds the credit).
module vend_txn_controller #(
    parameter int PRICE          = 3,
    parameter int CREDIT_W       = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin_req,
    output logic [1:0]          coin_ack,
    input  logic                cancel,
    output logic                vend_req,
    input  logic                vend_done,
    output logic                chg_req,
    input  logic                chg_done,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t              state_r, state_s;
    logic [CREDIT_W-1:0] credit_r, credit_s;
    logic [1:0]          coin_ack_r, coin_ack_s;
    logic                rr_ptr_r, rr_ptr_s;
    logic                vend_req_r, vend_req_s;
    logic                chg_req_r, chg_req_s;
    logic                busy_r, busy_s;
    logic [1:0]          grant_s;
    logic [CREDIT_W-1:0] add_s;
    logic [CREDIT_W-1:0] sum_s;
    logic                timeout_s;

    // Coin grant: only while collecting, never right after an ack, never with cancel.
    always_comb begin
        grant_s = 2'b00;
        if ((state_r == IDLE || state_r == COLLECT) && !cancel && coin_ack_r == 2'b00) begin
            case (coin_req)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = rr_ptr_r ? 2'b10 : 2'b01;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    // Credit increment for the granted coin ($10 counts as two $5 units).
    always_comb begin
        add_s = CREDIT_W'(0);
        if (grant_s[1]) begin
            add_s = CREDIT_W'(2);
        end else if (grant_s[0]) begin
            add_s = CREDIT_W'(1);
        end else begin
            add_s = CREDIT_W'(0);
        end
        sum_s = credit_r + add_s;
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [TMO_W-1:0] tmo_cnt_r;

    assign timeout_s = (state_r == COLLECT) && (grant_s == 2'b00)
                       && (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

    // Idle-credit counter: counts grant-free cycles spent in COLLECT.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= TMO_W'(0);
        end else if (state_r != COLLECT || grant_s != 2'b00 || timeout_s) begin
            tmo_cnt_r <= TMO_W'(0);
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_s    = state_r;
        credit_s   = credit_r;
        coin_ack_s = grant_s;
        rr_ptr_s   = rr_ptr_r;
        vend_req_s = vend_req_r;
        chg_req_s  = chg_req_r;
        if (grant_s != 2'b00) begin
            rr_ptr_s = grant_s[0];
        end else begin
            rr_ptr_s = rr_ptr_r;
        end
        case (state_r)
            IDLE, COLLECT: begin
                if (state_r == COLLECT && (cancel || timeout_s)) begin
                    state_s   = CHANGE;
                    chg_req_s = 1'b1;
                end else if (grant_s != 2'b00) begin
                    credit_s = sum_s;
                    if (sum_s >= PRICE_C) begin
                        state_s    = VEND;
                        vend_req_s = 1'b1;
                    end else begin
                        state_s = COLLECT;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            VEND: begin
                if (vend_done) begin
                    credit_s   = credit_r - PRICE_C;
                    vend_req_s = 1'b0;
                    if (credit_r > PRICE_C) begin
                        state_s   = CHANGE;
                        chg_req_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = VEND;
                end
            end
            CHANGE: begin
                if (chg_done) begin
                    credit_s = credit_r - CREDIT_W'(1);
                    if (credit_r <= CREDIT_W'(1)) begin
                        state_s   = IDLE;
                        chg_req_s = 1'b0;
                    end else begin
                        state_s = CHANGE;
                    end
                end else begin
                    state_s = CHANGE;
                end
            end
            default: begin
                state_s    = IDLE;
                credit_s   = CREDIT_W'(0);
                coin_ack_s = 2'b00;
                vend_req_s = 1'b0;
                chg_req_s  = 1'b0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers; reset discards all credit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            credit_r   <= CREDIT_W'(0);
            coin_ack_r <= 2'b00;
            rr_ptr_r   <= 1'b0;
            vend_req_r <= 1'b0;
            chg_req_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            credit_r   <= credit_s;
            coin_ack_r <= coin_ack_s;
            rr_ptr_r   <= rr_ptr_s;
            vend_req_r <= vend_req_s;
            chg_req_r  <= chg_req_s;
            busy_r     <= busy_s;
        end
    end

    assign coin_ack = coin_ack_r;
    assign credit   = credit_r;
    assign vend_req = vend_req_r;
    assign chg_req  = chg_req_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Self-checking bench for vend_txn_controller (PRICE=3, CREDIT_W=4,
// TIMEOUT_CYCLES=10). Coin acks are checked by a scoreboard fed from the
// stimulus tasks; handshake outputs are checked inline in each task.
module tb_vend_txn_controller;

    localparam int PRICE    = 3;
    localparam int CREDIT_W = 4;
    localparam int TMO      = 10;

    typedef struct packed {
        logic [1:0] ack;
        logic [3:0] credit;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] coin_req = 2'b00;
    logic [1:0] coin_ack;
    logic       cancel = 1'b0;
    logic       vend_req;
    logic       vend_done = 1'b0;
    logic       chg_req;
    logic       chg_done = 1'b0;
    logic [3:0] credit;
    logic       busy;
    logic [6:0] obs;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t m_e;

    assign obs = {vend_req, chg_req, busy, credit};

    vend_txn_controller #(
        .PRICE(PRICE), .CREDIT_W(CREDIT_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .coin_req(coin_req), .coin_ack(coin_ack),
        .cancel(cancel), .vend_req(vend_req), .vend_done(vend_done),
        .chg_req(chg_req), .chg_done(chg_done), .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every ack pulse must match the next expected (ack, credit).
    always @(negedge clk) begin
        if (coin_ack !== 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack: coin_ack=%b credit=%0d, none expected", coin_ack, credit);
            end else begin
                m_e = exp_q.pop_front();
                if ({coin_ack, credit} !== {m_e.ack, m_e.credit}) begin
                    failures++;
                    $display("FAIL sb_ack: ack=%b credit=%0d expected ack=%b credit=%0d",
                             coin_ack, credit, m_e.ack, m_e.credit);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] ack, input logic [3:0] cr);
        exp_t e;
        e.ack = ack;
        e.credit = cr;
        exp_q.push_back(e);
    endtask

    // Requester behaviour: hold the channel until acked, then drop it.
    task automatic insert(input int ch, input logic [3:0] exp_credit);
        bit seen = 1'b0;
        push_exp((ch == 0) ? 2'b01 : 2'b10, exp_credit);
        coin_req[ch] = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            cyc();
            if (coin_ack[ch] === 1'b1) seen = 1'b1;
        end
        coin_req[ch] = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL insert_ack_wait: ch=%0d seen=0 required ack within 8 cycles", ch);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        checks++;
        if ({coin_ack, obs} !== {2'b00, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL reset_state: {ack,vreq,creq,busy,credit}=%b required %b",
                     {coin_ack, obs}, {2'b00, 7'd0});
        end
    endtask

    task automatic test_round_robin();
        push_exp(2'b01, 4'd1);
        push_exp(2'b10, 4'd3);
        coin_req = 2'b11;
        cyc();
        checks++;
        if (coin_ack !== 2'b01) begin
            failures++;
            $display("FAIL rr_first: coin_ack=%b required 01", coin_ack);
        end
        coin_req[0] = 1'b0;
        cyc();
        checks++;
        if (coin_ack !== 2'b00) begin
            failures++;
            $display("FAIL rr_gap: coin_ack=%b required 00", coin_ack);
        end
        cyc();
        coin_req = 2'b00;
        checks++;
        if ({coin_ack, obs} !== {2'b10, 1'b1, 1'b0, 1'b1, 4'd3}) begin
            failures++;
            $display("FAIL rr_second_vend: {ack,vreq,creq,busy,credit}=%b required %b",
                     {coin_ack, obs}, {2'b10, 1'b1, 1'b0, 1'b1, 4'd3});
        end
        vend_done = 1'b1;
        cyc();
        vend_done = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL rr_vend_done: obs=%b required %b", obs, 7'd0);
        end
    endtask

    task automatic test_exact_price();
        insert(0, 4'd1);
        insert(0, 4'd2);
        insert(0, 4'd3);
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 4'd3}) begin
            failures++;
            $display("FAIL exact_vend_req: obs=%b required %b", obs, {1'b1, 1'b0, 1'b1, 4'd3});
        end
        cyc();
        cyc();
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 4'd3}) begin
            failures++;
            $display("FAIL exact_vend_hold: obs=%b required %b", obs, {1'b1, 1'b0, 1'b1, 4'd3});
        end
        vend_done = 1'b1;
        cyc();
        vend_done = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL exact_done: obs=%b required %b", obs, 7'd0);
        end
        cyc();
        cyc();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL exact_no_change: obs=%b required %b", obs, 7'd0);
        end
    endtask

    task automatic test_two_tens();
        insert(1, 4'd2);
        insert(1, 4'd4);
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 4'd4}) begin
            failures++;
            $display("FAIL tens_vend: obs=%b required %b", obs, {1'b1, 1'b0, 1'b1, 4'd4});
        end
        vend_done = 1'b1;
        cyc();
        vend_done = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 4'd1}) begin
            failures++;
            $display("FAIL tens_change: obs=%b required %b", obs, {1'b0, 1'b1, 1'b1, 4'd1});
        end
        chg_done = 1'b1;
        cyc();
        chg_done = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL tens_idle: obs=%b required %b", obs, 7'd0);
        end
    endtask

    task automatic test_cancel();
        insert(1, 4'd2);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 4'd2}) begin
            failures++;
            $display("FAIL cancel_change: obs=%b required %b", obs, {1'b0, 1'b1, 1'b1, 4'd2});
        end
        chg_done = 1'b1;
        cyc();
        chg_done = 1'b0;
        cyc();
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 4'd1}) begin
            failures++;
            $display("FAIL cancel_chg1: obs=%b required %b", obs, {1'b0, 1'b1, 1'b1, 4'd1});
        end
        chg_done = 1'b1;
        cyc();
        chg_done = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL cancel_chg0: obs=%b required %b", obs, 7'd0);
        end
        // unsolicited handshakes and cancel in IDLE are ignored
        vend_done = 1'b1;
        chg_done = 1'b1;
        cancel = 1'b1;
        cyc();
        vend_done = 1'b0;
        chg_done = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL unsolicited: obs=%b required %b", obs, 7'd0);
        end
        // cancel coincident with a coin in IDLE: no ack
        coin_req = 2'b01;
        cyc();
        cancel = 1'b0;
        coin_req = 2'b00;
        checks++;
        if ({coin_ack, obs} !== {2'b00, 7'd0}) begin
            failures++;
            $display("FAIL cancel_coin_idle: {ack,obs}=%b required %b", {coin_ack, obs}, 9'd0);
        end
        insert(0, 4'd1);
        cyc();
        // cancel coincident with a coin in COLLECT: no ack, refund
        coin_req = 2'b10;
        cancel = 1'b1;
        cyc();
        coin_req = 2'b00;
        cancel = 1'b0;
        checks++;
        if ({coin_ack, obs} !== {2'b00, 1'b0, 1'b1, 1'b1, 4'd1}) begin
            failures++;
            $display("FAIL cancel_coin_collect: {ack,obs}=%b required %b",
                     {coin_ack, obs}, {2'b00, 1'b0, 1'b1, 1'b1, 4'd1});
        end
        chg_done = 1'b1;
        cyc();
        chg_done = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL cancel_collect_idle: obs=%b required %b", obs, 7'd0);
        end
    endtask

    task automatic test_vend_hold_and_reset();
        push_exp(2'b10, 4'd2);
        push_exp(2'b10, 4'd4);
        coin_req = 2'b10;
        cyc();
        cyc();
        cyc();
        checks++;
        if ({coin_ack, obs} !== {2'b10, 1'b1, 1'b0, 1'b1, 4'd4}) begin
            failures++;
            $display("FAIL hold_second: {ack,obs}=%b required %b",
                     {coin_ack, obs}, {2'b10, 1'b1, 1'b0, 1'b1, 4'd4});
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({coin_ack, vend_req} !== {2'b00, 1'b1}) begin
                failures++;
                $display("FAIL hold_in_vend: {ack,vreq}=%b required 001", {coin_ack, vend_req});
            end
        end
        vend_done = 1'b1;
        cyc();
        vend_done = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 4'd1}) begin
            failures++;
            $display("FAIL hold_vend_done: obs=%b required %b", obs, {1'b0, 1'b1, 1'b1, 4'd1});
        end
        cyc();
        coin_req = 2'b00;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if ({coin_ack, obs} !== {2'b00, 7'd0}) begin
            failures++;
            $display("FAIL reset_in_change: {ack,obs}=%b required %b", {coin_ack, obs}, 9'd0);
        end
    endtask

    task automatic test_timeout();
        insert(0, 4'd1);
`ifdef VEND_TIMEOUT_EN
        repeat (TMO - 1) cyc();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 4'd1}) begin
            failures++;
            $display("FAIL timeout_early: obs=%b required %b", obs, {1'b0, 1'b0, 1'b1, 4'd1});
        end
        cyc();
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 4'd1}) begin
            failures++;
            $display("FAIL timeout_fire: obs=%b required %b", obs, {1'b0, 1'b1, 1'b1, 4'd1});
        end
`else
        repeat (3 * TMO) cyc();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 4'd1}) begin
            failures++;
            $display("FAIL no_timeout: obs=%b required %b", obs, {1'b0, 1'b0, 1'b1, 4'd1});
        end
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
`endif
        chg_done = 1'b1;
        cyc();
        chg_done = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL timeout_idle: obs=%b required %b", obs, 7'd0);
        end
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_exact_price();
        test_two_tens();
        test_cancel();
        test_vend_hold_and_reset();
        test_timeout();
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: pending=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
